// File: rtl/gray_receiver_pkg.sv
// -----------------------------------------------------------------------------
// gray_receiver_pkg
// Shared definitions for the Gray-code receiver:
//   state_e       - receiver FSM states (ACQ = acquiring, TRACK = locked)
//   ERR_CNT_W     - width of the error counter
//   ERR_CNT_MAX   - saturation value of the error counter
// -----------------------------------------------------------------------------
package gray_receiver_pkg;

  typedef enum logic {
    ST_ACQ   = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage : gray_receiver_pkg

// File: rtl/gray_decoder.sv
// -----------------------------------------------------------------------------
// gray_decoder
// Purely combinational Gray-to-binary converter; counterpart of the Gray
// encoder on the transmitting side.
// Ports:
//   i_gray  [LEN-1:0]  Gray-coded word
//   o_bin   [LEN-1:0]  binary value
// -----------------------------------------------------------------------------
module gray_decoder #(
  parameter int LEN = 10
) (
  input  logic [LEN-1:0] i_gray,
  output logic [LEN-1:0] o_bin
);

  // Binary bit i is the XOR of all Gray bits at or above i. Writing each bit
  // as a reduction over a slice avoids a ripple chain through o_bin itself.
  for (genvar i = 0; i < LEN; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[LEN-1:i];
  end

endmodule : gray_decoder

// File: rtl/gray_receiver.sv
// -----------------------------------------------------------------------------
// gray_receiver
// Synchronizes a Gray-coded count from a foreign clock domain, decodes it to
// binary and classifies every change as a legal +1 step, a legal -1 step
// (both modulo 2^LEN) or an error. After an error the receiver drops lock and
// re-acquires on the first cycle the synchronized input is stable.
// Ports:
//   clk       local clock, rising edge
//   rst_n     asynchronous active-low reset
//   gray_in   [LEN-1:0] Gray count, asynchronous to clk
//   bin       [LEN-1:0] decoded value of the last accepted Gray word
//   valid     1-cycle pulse on a legal step
//   up        1-cycle pulse with valid on a +1 step
//   down      1-cycle pulse with valid on a -1 step
//   err       1-cycle pulse on an illegal change
//   err_cnt   [7:0] saturating error count
//   locked    high while tracking a valid reference
// -----------------------------------------------------------------------------
module gray_receiver
  import gray_receiver_pkg::*;
#(
  parameter int LEN         = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN-1:0]       gray_in,
  output logic [LEN-1:0]       bin,
  output logic                 valid,
  output logic                 up,
  output logic                 down,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 locked
);

  localparam logic [LEN-1:0] STEP_UP   = LEN'(1);
  localparam logic [LEN-1:0] STEP_DOWN = '1;

  // Synchronizer and history
  logic [LEN-1:0] r_sync [SYNC_STAGES];
  logic [LEN-1:0] r_sync_d;
  logic [LEN-1:0] w_sync;
  logic [LEN-1:0] w_sync_bin;
  logic [LEN-1:0] w_delta;

  // FSM and output registers
  state_e               r_state,   w_state_next;
  logic [LEN-1:0]       r_ref,     w_ref_next;
  logic [LEN-1:0]       r_bin,     w_bin_next;
  logic                 r_valid,   w_valid_next;
  logic                 r_up,      w_up_next;
  logic                 r_down,    w_down_next;
  logic                 r_err,     w_err_next;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_next;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // NOTE: the synchronizer is an array of flops, but it is still reset here:
  // the ACQ comparison of sync against sync_d must start from a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sync_d <= w_sync;
    end
  end

  gray_decoder #(
    .LEN (LEN)
  ) u_decoder (
    .i_gray (w_sync),
    .o_bin  (w_sync_bin)
  );

  // Wraps naturally at LEN bits, so 0x3FF -> 0x000 still yields +1.
  assign w_delta = w_sync_bin - r_bin;

  // NOTE: every signal written below gets a default first so that no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_ref_next     = r_ref;
    w_bin_next     = r_bin;
    w_valid_next   = 1'b0;
    w_up_next      = 1'b0;
    w_down_next    = 1'b0;
    w_err_next     = 1'b0;
    w_err_cnt_next = r_err_cnt;

    case (r_state)
      ST_ACQ: begin
        // Stable for one cycle: take it as the new reference.
        if (w_sync == r_sync_d) begin
          w_ref_next   = w_sync;
          w_bin_next   = w_sync_bin;
          w_state_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_sync != r_ref) begin
          if (w_delta == STEP_UP) begin
            w_valid_next = 1'b1;
            w_up_next    = 1'b1;
            w_ref_next   = w_sync;
            w_bin_next   = w_sync_bin;
          end else if (w_delta == STEP_DOWN) begin
            w_valid_next = 1'b1;
            w_down_next  = 1'b1;
            w_ref_next   = w_sync;
            w_bin_next   = w_sync_bin;
          end else begin
            // Non-adjacent change: keep the old value and re-acquire.
            w_err_next   = 1'b1;
            w_state_next = ST_ACQ;
            if (r_err_cnt != ERR_CNT_MAX) w_err_cnt_next = r_err_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = ST_ACQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ACQ;
      r_ref     <= '0;
      r_bin     <= '0;
      r_valid   <= 1'b0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ref     <= w_ref_next;
      r_bin     <= w_bin_next;
      r_valid   <= w_valid_next;
      r_up      <= w_up_next;
      r_down    <= w_down_next;
      r_err     <= w_err_next;
      r_err_cnt <= w_err_cnt_next;
    end
  end

  assign bin     = r_bin;
  assign valid   = r_valid;
  assign up      = r_up;
  assign down    = r_down;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign locked  = (r_state == ST_TRACK);

endmodule : gray_receiver

// File: tb/tb_gray_receiver.sv
// -----------------------------------------------------------------------------
// tb_gray_receiver
// Self-checking bench for gray_receiver (LEN=10, SYNC_STAGES=2). A behavioural
// model computes expected outputs from the sampled input history using plain
// integer arithmetic; a compare process checks every cycle out of reset, and
// directed scenarios pin key values with literal expectations.
// -----------------------------------------------------------------------------
module tb_gray_receiver;

  localparam int LEN = 10;
  localparam int S   = 2;
  localparam int MOD = 1 << LEN;

  logic           clk;
  logic           rst_n;
  logic [LEN-1:0] gray_in;
  logic [LEN-1:0] bin;
  logic           valid, up, down, err, locked;
  logic [7:0]     err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  gray_receiver #(
    .LEN         (LEN),
    .SYNC_STAGES (S)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gray_in (gray_in),
    .bin     (bin),
    .valid   (valid),
    .up      (up),
    .down    (down),
    .err     (err),
    .err_cnt (err_cnt),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LEN-1:0] gray_of(input int b);
    logic [LEN-1:0] v;
    v = LEN'(b);
    return v ^ (v >> 1);
  endfunction

  // Binary value = XOR of the Gray word with all of its right shifts.
  function automatic logic [LEN-1:0] bin_of(input logic [LEN-1:0] g);
    logic [LEN-1:0] b;
    b = g;
    for (int s = 1; s < LEN; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // ---------------- behavioural model ----------------
  logic [LEN-1:0] samp [$];      // gray_in as sampled at each rising edge
  logic           m_locked;
  logic [LEN-1:0] m_ref, m_bin;
  logic           m_valid, m_up, m_down, m_err;
  int             m_cnt;

  always @(posedge clk or negedge rst_n) begin : model
    logic [LEN-1:0] cur, prev;
    int d;
    if (!rst_n) begin
      samp.delete();
      for (int i = 0; i <= S; i++) samp.push_back('0);
      m_locked = 1'b0; m_ref = '0; m_bin = '0; m_cnt = 0;
      m_valid = 1'b0; m_up = 1'b0; m_down = 1'b0; m_err = 1'b0;
    end else begin
      samp.push_back(gray_in);
      // Decision at this edge sees the word sampled S edges ago, and the one before it.
      cur  = samp[samp.size()-1-S];
      prev = samp[samp.size()-2-S];
      if (samp.size() > S + 4) void'(samp.pop_front());
      m_valid = 1'b0; m_up = 1'b0; m_down = 1'b0; m_err = 1'b0;
      if (!m_locked) begin
        if (cur == prev) begin
          m_ref = cur; m_bin = bin_of(cur); m_locked = 1'b1;
        end
      end else if (cur != m_ref) begin
        d = (int'(bin_of(cur)) - int'(m_bin) + MOD) % MOD;
        if (d == 1) begin
          m_valid = 1'b1; m_up = 1'b1; m_ref = cur; m_bin = bin_of(cur);
        end else if (d == MOD - 1) begin
          m_valid = 1'b1; m_down = 1'b1; m_ref = cur; m_bin = bin_of(cur);
        end else begin
          m_err = 1'b1; m_locked = 1'b0;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int up_seen    = 0;
  int valid_seen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("cycle {bin,valid,up,down,err,err_cnt,locked}",
            32'({bin, valid, up, down, err, err_cnt, locked}),
            32'({m_bin, m_valid, m_up, m_down, m_err, 8'(m_cnt), m_locked}));
      if (valid) valid_seen++;
      if (up)    up_seen++;
    end
  end

  // ---------------- helpers ----------------
  int src_bin;

  task automatic drive_bin(input int b);
    @(negedge clk);
    src_bin = b % MOD;
    gray_in = gray_of(src_bin);
  endtask

  task automatic wait_err(input string name);
    int n = 0;
    while (!err && n < 10) begin @(negedge clk); n++; end
    check(name, 32'(err), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!valid && n < 10) begin @(negedge clk); n++; end
    check(name, 32'(valid), 32'd1);
  endtask

  task automatic wait_lock(input string name);
    int n = 0;
    while (!locked && n < 12) begin @(negedge clk); n++; end
    check(name, 32'(locked), 32'd1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({bin, valid, up, down, err, err_cnt, locked}), 32'd0);
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    int base, vbase;

    // 1. Reset with GRAY_IN = 0
    rst_n   = 1'b0;
    gray_in = '0;
    src_bin = 0;
    #3;
    check_all_zero("reset_outputs_before_clock");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs_held");
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lock_by_edge3", 32'(locked), 32'd1);
    check("bin_after_lock", 32'(bin), 32'd0);
    check("no_valid_after_reset", 32'(valid_seen), 32'd0);

    // 2. Full count 1..1023 then wrap to 0, one step per 8 cycles
    base = up_seen;
    for (int i = 1; i <= MOD; i++) begin
      drive_bin(i);
      repeat (7) @(negedge clk);
    end
    check("up_pulses_full_count", 32'(up_seen - base), 32'd1024);
    check("bin_after_wrap_up", 32'(bin), 32'd0);
    check("err_cnt_after_count", 32'(err_cnt), 32'd0);

    // 3. 0x000 -> 0x200 is a DOWN step to 0x3FF
    drive_bin(MOD - 1);
    check("gray_of_3ff", 32'(gray_in), 32'h200);
    wait_valid("down_wrap_valid");
    check("down_wrap_down", 32'(down), 32'd1);
    check("down_wrap_bin", 32'(bin), 32'h3FF);

    // 4. Single-bit non-adjacent change from BIN=0x155
    @(negedge clk); #2 rst_n = 1'b0;
    gray_in = '0; src_bin = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    wait_lock("relock_after_reset");
    for (int i = 1; i <= 'h155; i++) begin
      drive_bin(i);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("bin_at_155", 32'(bin), 32'h155);
    check("gray_at_155", 32'(gray_in), 32'h1FF);
    vbase = valid_seen;
    @(negedge clk);
    gray_in = 10'h3FF;
    src_bin = int'(bin_of(gray_in));
    wait_err("single_bit_err");
    check("err_cnt_one", 32'(err_cnt), 32'd1);
    check("unlocked_on_err", 32'(locked), 32'd0);
    check("bin_holds_on_err", 32'(bin), 32'h155);
    wait_lock("relock_after_err");
    check("bin_after_relock", 32'(bin), 32'h2AA);
    check("no_valid_on_relock", 32'(valid_seen - vbase), 32'd0);

    // 5. Random mix of holds, legal steps, jumps and bit flips
    for (int c = 0; c < 2000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r >= 4 && r <= 5)      drive_bin(src_bin + 1);
      else if (r >= 6 && r <= 7) drive_bin(src_bin + MOD - 1);
      else if (r == 8)           drive_bin($urandom_range(0, MOD - 1));
      else if (r == 9) begin
        @(negedge clk);
        gray_in = gray_of(src_bin) ^ (LEN'(1) << $urandom_range(0, LEN - 1));
        src_bin = int'(bin_of(gray_in));
      end else @(negedge clk);
    end

    // 6. 300 forced illegal jumps, each followed by relock
    for (int j = 0; j < 300; j++) begin
      repeat (4) @(negedge clk);
      drive_bin(src_bin + int'($urandom_range(2, MOD - 2)));
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);
    drive_bin(src_bin + 5);
    wait_err("err_at_saturation");
    check("err_cnt_holds", 32'(err_cnt), 32'd255);

    // 7. Asynchronous reset while VALID is high
    repeat (6) @(negedge clk);
    drive_bin(src_bin + 1);
    begin
      int n = 0;
      @(posedge clk); #1;
      while (!valid && n < 10) begin @(posedge clk); #1; n++; end
    end
    check("valid_before_async_reset", 32'(valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_clears_outputs");
    @(negedge clk); #2 rst_n = 1'b1;
    #1;
    check("acq_after_release", 32'(locked), 32'd0);
    repeat (12) @(negedge clk);
    check("locked_after_release", 32'(locked), 32'd1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_gray_receiver
